// File: rtl/b12_keypad.sv
// b12_keypad: input conditioning in front of the b12 game controller.
// The four colour buttons and the start button are synchronised and debounced.
// Each physical press then gives one clean pulse: a one-hot k pulse for a single key,
// a multi_err pulse for a chord, and a start pulse for the start button.
module b12_keypad #(
  parameter int DEB_CYCLES = 4,
  parameter int CW         = 3
) (
  input  logic       clock,
  input  logic       nreset,
  input  logic [3:0] raw_key,
  input  logic       raw_start,
  output logic [3:0] k,
  output logic       start,
  output logic       multi_err,
  output logic       key_busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DEB   = 3'd1;
  localparam logic [2:0] S_PRESS = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_REL   = 3'd4;

  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [3:0]    key_sync1_q, key_sync2_q;
  logic          start_sync1_q, start_sync2_q;
  logic [3:0]    s_key;
  logic          s_start;

  logic [2:0]    state_q, state_d;
  logic [3:0]    pat_q, pat_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    k_q, k_d;
  logic          multi_err_q, multi_err_d;
  logic          key_busy_q, key_busy_d;
  logic          pat_onehot;

  logic          st_lvl_q, st_lvl_d;
  logic          st_lvl_prev_q;
  logic [CW-1:0] scnt_q, scnt_d;
  logic          start_q, start_d;

  assign s_key   = key_sync2_q;
  assign s_start = start_sync2_q;

  // Two-flop synchronisers for the asynchronous button inputs
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      key_sync1_q   <= '0;
      key_sync2_q   <= '0;
      start_sync1_q <= 1'b0;
      start_sync2_q <= 1'b0;
    end else begin
      key_sync1_q   <= raw_key;
      key_sync2_q   <= key_sync1_q;
      start_sync1_q <= raw_start;
      start_sync2_q <= start_sync1_q;
    end
  end

  assign pat_onehot = (pat_q != 4'd0) && ((pat_q & (pat_q - 4'd1)) == 4'd0);

  // Key FSM next state; k and multi_err are computed against the next state so the
  // registered pulse coincides exactly with the cycle spent in PRESS
  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    cnt_d       = cnt_q;
    k_d         = 4'd0;
    multi_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (s_key != 4'd0) begin
          pat_d   = s_key;
          cnt_d   = '0;
          state_d = S_DEB;
        end
      end
      S_DEB: begin
        if (s_key != pat_q) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_PRESS;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_PRESS: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (s_key == 4'd0) begin
          cnt_d   = '0;
          state_d = S_REL;
        end
      end
      S_REL: begin
        if (s_key != 4'd0) begin
          state_d = S_HOLD;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (state_d == S_PRESS) begin
      if (pat_onehot) begin
        k_d = pat_q;
      end else begin
        multi_err_d = 1'b1;
      end
    end
    key_busy_d = (state_d != S_IDLE);
  end

  // Key FSM state, pattern, counter and registered key outputs
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q     <= S_IDLE;
      pat_q       <= '0;
      cnt_q       <= '0;
      k_q         <= '0;
      multi_err_q <= 1'b0;
      key_busy_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      multi_err_q <= multi_err_d;
      key_busy_q  <= key_busy_d;
    end
  end

  // Start debouncer: the level follows s_start only after it has disagreed for
  // DEB_CYCLES consecutive samples; the pulse is taken from the level's rising edge,
  // one cycle late, so that it lines up with a key pressed at the same moment
  always_comb begin
    st_lvl_d = st_lvl_q;
    scnt_d   = scnt_q;
    if (s_start == st_lvl_q) begin
      scnt_d = '0;
    end else if (scnt_q == CNT_MAX) begin
      st_lvl_d = s_start;
      scnt_d   = '0;
    end else begin
      scnt_d = scnt_q + CNT_ONE;
    end
    start_d = st_lvl_q & ~st_lvl_prev_q;
  end

  // Start debouncer state and registered start pulse
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      st_lvl_q      <= 1'b0;
      st_lvl_prev_q <= 1'b0;
      scnt_q        <= '0;
      start_q       <= 1'b0;
    end else begin
      st_lvl_q      <= st_lvl_d;
      st_lvl_prev_q <= st_lvl_q;
      scnt_q        <= scnt_d;
      start_q       <= start_d;
    end
  end

  assign k         = k_q;
  assign multi_err = multi_err_q;
  assign key_busy  = key_busy_q;
  assign start     = start_q;

endmodule

// File: tb/tb_b12_keypad.sv
// tb_b12_keypad: directed and random stimulus for b12_keypad. The expected outputs
// come from a run-length model of the synchronised button samples.
module tb_b12_keypad;

  localparam int DEB = 4;

  logic       clock;
  logic       nreset;
  logic [3:0] raw_key;
  logic       raw_start;
  logic [3:0] k;
  logic       start;
  logic       multi_err;
  logic       key_busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [3:0] m_sk1, m_sk2;
  logic       m_ss1, m_ss2;
  logic [3:0] m_pat;
  int         m_run, m_zr, m_dc;
  bit         m_skip, m_locked, m_lvl, m_st_pend;
  logic [3:0] exp_k;
  logic       exp_err, exp_busy, exp_start;

  // Pulse tallies for the directed scenarios
  int k_pulses = 0, err_pulses = 0, st_pulses = 0, both_pulses = 0;

  b12_keypad #(.DEB_CYCLES(DEB), .CW(3)) dut (
    .clock     (clock),
    .nreset    (nreset),
    .raw_key   (raw_key),
    .raw_start (raw_start),
    .k         (k),
    .start     (start),
    .multi_err (multi_err),
    .key_busy  (key_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a press is accepted once DEB+1 identical nonzero samples arrive while armed;
  // a sample that breaks a run is discarded. After a press one sample is ignored, and the
  // model stays locked until DEB+1 consecutive zero samples arrive.
  always @(posedge clock or negedge nreset) begin
    logic [3:0] sk;
    logic       ss;
    if (!nreset) begin
      m_sk1 = 0; m_sk2 = 0; m_ss1 = 0; m_ss2 = 0; m_pat = 0;
      m_run = 0; m_zr = 0; m_dc = 0;
      m_skip = 0; m_locked = 0; m_lvl = 0; m_st_pend = 0;
      exp_k = 0; exp_err = 0; exp_busy = 0; exp_start = 0;
    end else begin
      sk = m_sk2; ss = m_ss2;
      m_sk2 = m_sk1; m_sk1 = raw_key;
      m_ss2 = m_ss1; m_ss1 = raw_start;
      exp_k = 0; exp_err = 0;
      if (m_skip) begin
        m_skip = 0; m_locked = 1; m_zr = 0;
      end else if (m_locked) begin
        if (sk == 0) m_zr++; else m_zr = 0;
        if (m_zr == DEB + 1) begin
          m_locked = 0; m_run = 0;
        end
      end else begin
        if (m_run > 0) begin
          if (sk == m_pat) m_run++; else m_run = 0;
        end else if (sk != 0) begin
          m_pat = sk; m_run = 1;
        end
        if (m_run == DEB + 1) begin
          if ($countones(m_pat) == 1) exp_k = m_pat; else exp_err = 1;
          m_skip = 1; m_run = 0;
        end
      end
      exp_busy = m_skip || m_locked || (m_run > 0);
      exp_start = m_st_pend;
      m_st_pend = 0;
      if (ss != m_lvl) begin
        m_dc++;
        if (m_dc == DEB) begin
          m_lvl = ss; m_dc = 0;
          if (m_lvl) m_st_pend = 1;
        end
      end else begin
        m_dc = 0;
      end
    end
  end

  // Compare every output against the model away from the active edge
  always @(negedge clock) begin
    check_output("k", {28'd0, k}, {28'd0, exp_k});
    check_output("start", {31'd0, start}, {31'd0, exp_start});
    check_output("multi_err", {31'd0, multi_err}, {31'd0, exp_err});
    check_output("key_busy", {31'd0, key_busy}, {31'd0, exp_busy});
    if (k != 0) k_pulses++;
    if (multi_err) err_pulses++;
    if (start) st_pulses++;
    if (start && k != 0) both_pulses++;
  end

  // Drive both raw inputs and hold them for n cycles; returns just after a falling edge
  task automatic apply_stimulus(input logic [3:0] key, input logic st, input int n);
    raw_key = key;
    raw_start = st;
    repeat (n) @(negedge clock);
    #1;
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once
  task automatic pulse_reset();
    nreset = 1'b0;
    #1;
    check_output("async_rst_k", {28'd0, k}, 32'd0);
    check_output("async_rst_busy", {31'd0, key_busy}, 32'd0);
    check_output("async_rst_start", {31'd0, start}, 32'd0);
    check_output("async_rst_err", {31'd0, multi_err}, 32'd0);
    @(negedge clock);
    #1;
    nreset = 1'b1;
  endtask

  initial begin
    int k0, e0, s0, b0;
    logic [3:0] key;
    nreset = 1'b0;
    raw_key = 4'd0;
    raw_start = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check_output("reset_k", {28'd0, k}, 32'd0);
    check_output("reset_busy", {31'd0, key_busy}, 32'd0);
    nreset = 1'b1;
    apply_stimulus(4'd0, 1'b0, 3);

    // Single clean GREEN press held long
    k0 = k_pulses;
    apply_stimulus(4'b0010, 1'b0, 20);
    apply_stimulus(4'b0000, 1'b0, 12);
    check_output("t1_k_pulses", k_pulses - k0, 1);

    // Bouncing RED then a stable press
    k0 = k_pulses;
    for (int i = 0; i < 8; i++) apply_stimulus((i % 2 == 0) ? 4'b0001 : 4'b0000, 1'b0, 1);
    check_output("t2_bounce_pulses", k_pulses - k0, 0);
    apply_stimulus(4'b0001, 1'b0, 10);
    apply_stimulus(4'b0000, 1'b0, 12);
    check_output("t2_k_pulses", k_pulses - k0, 1);

    // Chord rejected, then a clean YELLOW press
    k0 = k_pulses; e0 = err_pulses;
    apply_stimulus(4'b0101, 1'b0, 10);
    apply_stimulus(4'b0000, 1'b0, 12);
    check_output("t3_err_pulses", err_pulses - e0, 1);
    check_output("t3_chord_k", k_pulses - k0, 0);
    apply_stimulus(4'b0100, 1'b0, 10);
    apply_stimulus(4'b0000, 1'b0, 12);
    check_output("t3_k_pulses", k_pulses - k0, 1);

    // Short release glitch while held, then a true release and re-press
    k0 = k_pulses;
    apply_stimulus(4'b0001, 1'b0, 10);
    apply_stimulus(4'b0000, 1'b0, 2);
    apply_stimulus(4'b0001, 1'b0, 10);
    apply_stimulus(4'b0000, 1'b0, 12);
    check_output("t4_glitch_pulses", k_pulses - k0, 1);
    apply_stimulus(4'b0001, 1'b0, 10);
    apply_stimulus(4'b0000, 1'b0, 12);
    check_output("t4_repress_pulses", k_pulses - k0, 2);

    // Start and BLUE pressed together pulse in the same cycle; start release is silent
    k0 = k_pulses; s0 = st_pulses; b0 = both_pulses;
    apply_stimulus(4'b1000, 1'b1, 10);
    apply_stimulus(4'b0000, 1'b0, 12);
    check_output("t5_start_pulses", st_pulses - s0, 1);
    check_output("t5_k_pulses", k_pulses - k0, 1);
    check_output("t5_same_cycle", both_pulses - b0, 1);

    // Reset in the middle of debouncing a held key
    k0 = k_pulses;
    apply_stimulus(4'b0001, 1'b0, 4);
    pulse_reset();
    apply_stimulus(4'b0001, 1'b0, 15);
    apply_stimulus(4'b0000, 1'b0, 12);
    check_output("t6_k_pulses", k_pulses - k0, 1);

    // Random button activity including chords, bounces and occasional resets
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: key = 4'b0001 << $urandom_range(0, 3);
        5, 6:          key = 4'($urandom_range(0, 15));
        default:       key = 4'd0;
      endcase
      apply_stimulus(key, ($urandom_range(0, 3) == 0), $urandom_range(1, 12));
      if ($urandom_range(0, 39) == 0) pulse_reset();
    end
    apply_stimulus(4'd0, 1'b0, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
